// File: rtl/readout_pkg.sv
// Shared types and default sizing for the capture readout controller.
package readout_pkg;

  localparam int DEFAULT_DATA_W      = 16;
  localparam int DEFAULT_ADDR_W      = 8;
  localparam int DEFAULT_NUM_SAMPLES = 256;

  // Words the readout path may hold at once (in flight from memory + buffered).
  localparam int MAX_OUTSTANDING = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_READ  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  function automatic logic [1:0] words_outstanding(input logic       in_flight,
                                                   input logic [1:0] buffered);
    return buffered + 2'(in_flight);
  endfunction

endpackage

// File: rtl/readout_skid.sv
// Two-entry flow-through output buffer; an arriving word is presented the same
// cycle when the buffer is empty, otherwise it queues behind the buffered words.
module readout_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] entry_q [2];
  logic [W-1:0] entry_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         has_head;
  logic         pop;
  logic         pop_buf;
  logic         push;

  always_comb begin
    has_head  = (count_q != 2'd0);
    out_valid = has_head || in_valid;
    out_data  = '0;
    if (has_head) begin
      out_data = entry_q[rd_ptr_q];
    end else if (in_valid) begin
      out_data = in_data;
    end
    pop     = out_valid && out_ready;
    pop_buf = pop && has_head;
    // An arriving word consumed directly from the bypass path is never stored.
    push    = in_valid && !(pop && !has_head);

    for (int i = 0; i < 2; i++) begin
      entry_d[i] = (push && (wr_ptr_q == 1'(i))) ? in_data : entry_q[i];
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop_buf;
    count_d  = count_q + 2'(push) - 2'(pop_buf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= entry_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

  // The issuing side must never push into a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop_buf && (count_q == 2'd2)));

endmodule

// File: rtl/readout_ctrl.sv
// Capture handshake with the sampler domain, then streams NUM_SAMPLES words from
// sample memory to a ready/valid port with at most two words outstanding.
module readout_ctrl
  import readout_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int NUM_SAMPLES = DEFAULT_NUM_SAMPLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish_r_sync,
  output logic              sampler_start_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issued_all_q, issued_all_d;
  logic              in_flight_q, in_flight_d;
  logic              in_flight_last_q, in_flight_last_d;
  logic              req_q, req_d;

  logic [1:0]        skid_count;
  logic              skid_valid;
  logic [DATA_W:0]   skid_data;
  logic              credit_ok;
  logic              xfer_last;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issued_all_d = issued_all_q;
    mem_rd_en    = 1'b0;
    done         = 1'b0;
    credit_ok    = (words_outstanding(in_flight_q, skid_count) < 2'(MAX_OUTSTANDING));
    xfer_last    = out_valid && out_ready && out_last;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !finish_r_sync) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (finish_r_sync) begin
          state_d      = ST_READ;
          addr_d       = '0;
          issued_all_d = 1'b0;
        end
      end
      ST_READ: begin
        mem_rd_en = !issued_all_q && credit_ok;
        // The address parks on the final word; issued_all stops re-issue.
        if (mem_rd_en) begin
          if (addr_q == LAST_ADDR) begin
            issued_all_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        if (xfer_last) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (!finish_r_sync) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_flight_d      = mem_rd_en;
    in_flight_last_d = mem_rd_en && (addr_q == LAST_ADDR);
    req_d            = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      issued_all_q     <= 1'b0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      req_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      issued_all_q     <= issued_all_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
      req_q            <= req_d;
    end
  end

  readout_skid #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_flight_q),
    .in_data   ({in_flight_last_q, mem_rdata}),
    .out_valid (skid_valid),
    .out_ready (out_ready),
    .out_data  (skid_data),
    .count     (skid_count)
  );

  assign sampler_start_req = req_q;
  assign mem_addr          = addr_q;
  assign busy              = (state_q != ST_IDLE);
  assign out_valid         = skid_valid;
  assign out_data          = skid_data[DATA_W-1:0];
  assign out_last          = skid_valid && skid_data[DATA_W];

endmodule

// File: doc/readout_ctrl.md
READOUT_CTRL -- requirements
Module: readout_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, sample word width.
REQ-002 Parameter ADDR_W, default 8, sample memory address width.
REQ-003 Parameter NUM_SAMPLES, default 256, words per capture; legal range 2..2**ADDR_W.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle capture request from control.
REQ-007 finish_r_sync  input  1  sampler finish level, already synchronized into clk domain.
REQ-008 sampler_start_req  output  1  registered request level toward sampler domain.
REQ-009 mem_rd_en  output  1  sample memory read strobe.
REQ-010 mem_addr  output  ADDR_W  sample memory read address.
REQ-011 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-012 out_valid  output  1; out_ready  input  1; out_data  output  DATA_W; out_last  output  1: readout stream.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at end of capture/readout cycle.

Function
REQ-015 FSM states SHALL be IDLE, REQ, READ, CLEAR.
REQ-016 IDLE: start=1 and finish_r_sync=0 -> REQ; start with finish_r_sync=1 or in any non-IDLE state SHALL be ignored.
REQ-017 REQ: sampler_start_req SHALL be 1; on finish_r_sync=1 -> READ, sampler_start_req 0 from the next cycle, read address cleared to 0.
REQ-018 READ: addresses 0..NUM_SAMPLES-1 SHALL be issued in order, at most one per cycle, only while (words in flight + words buffered) < 2.
REQ-019 Read address counter SHALL saturate at NUM_SAMPLES-1; no wrap, no re-issue.
REQ-020 Latency: finish_r_sync seen high in cycle N -> mem_rd_en addr 0 in N+1 -> out_valid in N+2 minimum.
REQ-021 With out_ready held 1, throughput SHALL be one word per cycle.
REQ-022 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0; transfer occurs when both 1.
REQ-023 out_last SHALL be 1 only with word NUM_SAMPLES-1.
REQ-024 READ -> CLEAR on the cycle the out_last word transfers.
REQ-025 CLEAR: wait finish_r_sync=0, then done=1 for one cycle and -> IDLE; if already 0, done in the first CLEAR cycle.
REQ-026 finish_r_sync falling during READ SHALL be ignored (no abort).
REQ-027 No word SHALL be dropped or duplicated under arbitrary out_ready patterns.

Reset
REQ-028 On rst_n=0: state IDLE; sampler_start_req, mem_rd_en, out_valid, out_last, busy, done = 0; mem_addr, out_data = 0; buffer empty.
REQ-029 Reset mid-operation SHALL discard buffered/in-flight words and SHALL NOT produce done.
REQ-030 After reset release, first start accepted on the first clk edge.

Structure
REQ-031 Package readout_pkg SHALL hold the state enum and default DATA_W/ADDR_W/NUM_SAMPLES constants.
REQ-032 2-entry output buffer SHALL be sub-module readout_skid (DATA_W+1 wide, carries last flag, reports occupancy to credit logic).
REQ-033 FSM, address counter and credit logic SHALL reside in readout_ctrl.

Verification
REQ-034 NUM_SAMPLES=4, out_ready=1, start, finish_r_sync high 3 cycles later -> 4 words addr 0..3 on consecutive cycles, out_last on 4th, finish low -> single done pulse.
REQ-035 out_ready toggling 1,0,0,1 repeating over 256-word readout -> memory-pattern data in order, none lost or duplicated, data stable while stalled.
REQ-036 start while busy and start with finish_r_sync=1 in IDLE -> ignored, sampler_start_req unchanged.
REQ-037 rst_n asserted after 10 words of READ -> all outputs 0 immediately, no done, next start runs a clean capture from addr 0.
REQ-038 finish_r_sync held high 20 cycles after last word -> state remains CLEAR, busy=1, done only after finish falls.
REQ-039 out_ready=0 for 50 cycles from first finish -> exactly 2 words issued (addr 0,1), mem_rd_en low thereafter until a transfer.
